xosera_bus_host: RTL and testbench

Parametrised host-side bus sequencer that turns queued 16-bit register commands into Xosera 8-bit `bus_*` strobe cycles (high byte, then low byte) with programmable setup, strobe and gap lengths. It replaces hand-timed `write_reg`/`read_reg`/`xvid_setw` stimulus: the same RTL drives `xosera_main` in simulation and serves as an on-FPGA self-test/host master. Read results return on a valid/ready response port.

---
 rtl/xosera_bus_host_pkg.sv | 38 +++
 rtl/xosera_cmd_fifo.sv | 54 +++++
 rtl/xosera_bus_host.sv | 168 ++++++++++++++++
 tb/tb_xosera_bus_host.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xosera_bus_host_pkg.sv
// Shared types for the Xosera host bus sequencer.
//   bh_mode_t  : byte selection of a queued command (WORD / HI / LO)
//   bh_cmd_t   : one queued command, 23 bits
//   bh_state_t : sequencer states
//   max3       : constant helper used to size the phase counter
package xosera_bus_host_pkg;

  typedef enum logic [1:0] {
    BH_WORD = 2'b00,
    BH_HI   = 2'b01,
    BH_LO   = 2'b10
  } bh_mode_t;

  // mode is kept as raw bits so the unused encoding 11 survives the FIFO
  // and is decoded as a WORD by the sequencer.
  typedef struct packed {
    logic        rd_nwr;
    logic [3:0]  reg_num;
    logic [1:0]  mode;
    logic [15:0] data;
  } bh_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETUP,
    ST_STROBE,
    ST_GAP,
    ST_RESP
  } bh_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/xosera_cmd_fifo.sv
// Synchronous command FIFO for the host bus sequencer.
// Ports:
//   clk, reset_i      : clock, asynchronous active-high reset (empties FIFO)
//   push, din         : write request / data (ignored when full)
//   pop, dout         : read request (ignored when empty) / head entry
//   full, empty       : status, derived from pointers with a wrap bit
module xosera_cmd_fifo
  import xosera_bus_host_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset_i,
  input  logic    push,
  input  bh_cmd_t din,
  input  logic    pop,
  output bh_cmd_t dout,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  bh_cmd_t      mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Same index with differing wrap bits means the writer lapped the reader.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/xosera_bus_host.sv
// Host-side Xosera bus sequencer: queued 16-bit register commands become
// 8-bit bus_* strobe cycles (high byte first) with programmable setup,
// strobe and gap lengths. Read results return on a valid/ready port.
// Ports:
//   clk, reset_i                       : clock, async active-high reset
//   cmd_valid_i/cmd_ready_o            : command handshake
//   cmd_rd_nwr_i, cmd_reg_num_i,
//   cmd_mode_i, cmd_data_i             : command fields
//   rsp_valid_o/rsp_ready_i,
//   rsp_data_o, rsp_reg_num_o          : read response
//   bus_cs_n_o, bus_rd_nwr_o, bus_bytesel_o,
//   bus_reg_num_o, bus_data_o, bus_data_i : Xosera 8-bit bus
//   busy_o                             : queued work or sequencer active
module xosera_bus_host
  import xosera_bus_host_pkg::*;
#(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 4,
  parameter int GAP_CYCLES    = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_rd_nwr_i,
  input  logic [3:0]  cmd_reg_num_i,
  input  logic [1:0]  cmd_mode_i,
  input  logic [15:0] cmd_data_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [15:0] rsp_data_o,
  output logic [3:0]  rsp_reg_num_o,
  output logic        bus_cs_n_o,
  output logic        bus_rd_nwr_o,
  output logic        bus_bytesel_o,
  output logic [3:0]  bus_reg_num_o,
  output logic [7:0]  bus_data_o,
  input  logic [7:0]  bus_data_i,
  output logic        busy_o
);

  localparam int MAX_CYC = max3(SETUP_CYCLES, STROBE_CYCLES, GAP_CYCLES);
  localparam int CW      = $clog2(MAX_CYC + 1);
  // Counter is loaded with length-1 on phase entry and the phase ends at 0.
  localparam logic [CW-1:0] SETUP_LOAD  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] STROBE_LOAD = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD    = CW'(GAP_CYCLES - 1);

  bh_cmd_t   cmd_in;
  bh_cmd_t   fifo_dout;
  logic      fifo_full;
  logic      fifo_empty;
  bh_state_t state;
  logic [CW-1:0] cnt;
  logic      cur_word;    // second (low) byte still owed after byte 0
  logic [7:0] cur_lo;     // low write byte kept for the second half of a WORD

  assign cmd_in      = {cmd_rd_nwr_i, cmd_reg_num_i, cmd_mode_i, cmd_data_i};
  assign cmd_ready_o = !fifo_full;
  assign busy_o      = !fifo_empty || (state != ST_IDLE);

  xosera_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_i (reset_i),
    .push    (cmd_valid_i),
    .din     (cmd_in),
    .pop     (state == ST_LOAD),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      cur_word      <= 1'b0;
      cur_lo        <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_data_o    <= '0;
      rsp_reg_num_o <= '0;
      bus_cs_n_o    <= 1'b1;
      bus_rd_nwr_o  <= 1'b1;
      bus_bytesel_o <= 1'b0;
      bus_reg_num_o <= '0;
      bus_data_o    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) state <= ST_LOAD;
        end
        ST_LOAD: begin
          // Bus fields are set up here so they are valid in the first SETUP cycle.
          cur_word      <= (fifo_dout.mode != BH_HI) && (fifo_dout.mode != BH_LO);
          cur_lo        <= fifo_dout.data[7:0];
          bus_rd_nwr_o  <= fifo_dout.rd_nwr;
          bus_reg_num_o <= fifo_dout.reg_num;
          bus_bytesel_o <= (fifo_dout.mode == BH_LO);
          if (fifo_dout.rd_nwr) begin
            bus_data_o <= '0;
            rsp_data_o <= '0;
          end else if (fifo_dout.mode == BH_LO) begin
            bus_data_o <= fifo_dout.data[7:0];
          end else begin
            bus_data_o <= fifo_dout.data[15:8];
          end
          cnt   <= SETUP_LOAD;
          state <= ST_SETUP;
        end
        ST_SETUP: begin
          if (cnt == '0) begin
            bus_cs_n_o <= 1'b0;
            cnt        <= STROBE_LOAD;
            state      <= ST_STROBE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_STROBE: begin
          if (cnt == '0) begin
            if (bus_rd_nwr_o) begin
              if (bus_bytesel_o) rsp_data_o[7:0]  <= bus_data_i;
              else               rsp_data_o[15:8] <= bus_data_i;
            end
            bus_cs_n_o <= 1'b1;
            cnt        <= GAP_LOAD;
            state      <= ST_GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (cur_word && !bus_bytesel_o) begin
            bus_bytesel_o <= 1'b1;
            bus_data_o    <= bus_rd_nwr_o ? 8'h00 : cur_lo;
            cnt           <= SETUP_LOAD;
            state         <= ST_SETUP;
          end else if (bus_rd_nwr_o) begin
            rsp_valid_o   <= 1'b1;
            rsp_reg_num_o <= bus_reg_num_o;
            state         <= ST_RESP;
          end else begin
            bus_rd_nwr_o  <= 1'b1;
            bus_bytesel_o <= 1'b0;
            bus_reg_num_o <= '0;
            bus_data_o    <= '0;
            state         <= ST_IDLE;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o   <= 1'b0;
            bus_rd_nwr_o  <= 1'b1;
            bus_bytesel_o <= 1'b0;
            bus_reg_num_o <= '0;
            bus_data_o    <= '0;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xosera_bus_host.sv
// Bench for xosera_bus_host: two instances (default timing and a fast
// 1/2/1 timing), a bus-side device model with a per-register read value,
// a strobe monitor and a command-level reference model.
module tb_xosera_bus_host;

  localparam int T0 = 4;   // strobe length of dut0
  localparam int T1 = 2;   // strobe length of dut1

  typedef struct {
    bit         rd;
    bit         bsel;
    logic [3:0] rnum;
    logic [7:0] data;
    int         len;
    int         start;
  } byte_t;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  rnum;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic        cmd_valid [2];
  logic        cmd_ready [2];
  logic        cmd_rd    [2];
  logic [3:0]  cmd_reg   [2];
  logic [1:0]  cmd_mode  [2];
  logic [15:0] cmd_data  [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [15:0] rsp_data  [2];
  logic [3:0]  rsp_reg   [2];
  logic        cs_n      [2];
  logic        bus_rd    [2];
  logic        bsel      [2];
  logic [3:0]  breg      [2];
  logic [7:0]  bdo       [2];
  logic [7:0]  bdi       [2];
  logic        busy      [2];
  int          low_cnt   [2];

  logic [15:0] rd_val [16];

  byte_t mon_q0[$], mon_q1[$], exp_q0[$], exp_q1[$];
  rsp_t  got_r0[$], got_r1[$], exp_r0[$], exp_r1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  xosera_bus_host #(.SETUP_CYCLES(1), .STROBE_CYCLES(T0), .GAP_CYCLES(4), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .reset_i(rst),
    .cmd_valid_i(cmd_valid[0]), .cmd_ready_o(cmd_ready[0]), .cmd_rd_nwr_i(cmd_rd[0]),
    .cmd_reg_num_i(cmd_reg[0]), .cmd_mode_i(cmd_mode[0]), .cmd_data_i(cmd_data[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]), .rsp_data_o(rsp_data[0]),
    .rsp_reg_num_o(rsp_reg[0]), .bus_cs_n_o(cs_n[0]), .bus_rd_nwr_o(bus_rd[0]),
    .bus_bytesel_o(bsel[0]), .bus_reg_num_o(breg[0]), .bus_data_o(bdo[0]),
    .bus_data_i(bdi[0]), .busy_o(busy[0])
  );

  xosera_bus_host #(.SETUP_CYCLES(1), .STROBE_CYCLES(T1), .GAP_CYCLES(1), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .reset_i(rst),
    .cmd_valid_i(cmd_valid[1]), .cmd_ready_o(cmd_ready[1]), .cmd_rd_nwr_i(cmd_rd[1]),
    .cmd_reg_num_i(cmd_reg[1]), .cmd_mode_i(cmd_mode[1]), .cmd_data_i(cmd_data[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]), .rsp_data_o(rsp_data[1]),
    .rsp_reg_num_o(rsp_reg[1]), .bus_cs_n_o(cs_n[1]), .bus_rd_nwr_o(bus_rd[1]),
    .bus_bytesel_o(bsel[1]), .bus_reg_num_o(breg[1]), .bus_data_o(bdo[1]),
    .bus_data_i(bdi[1]), .busy_o(busy[1])
  );

  // Device model: the register byte is only presented on the last strobe
  // cycle; every other cycle drives its complement, so an early sample is wrong.
  function automatic logic [7:0] dev_byte(input logic sel, input logic [15:0] v);
    return sel ? v[7:0] : v[15:8];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) low_cnt[i] <= cs_n[i] ? 0 : low_cnt[i] + 1;
  end

  assign bdi[0] = (!cs_n[0] && low_cnt[0] == T0 - 1) ? dev_byte(bsel[0], rd_val[breg[0]])
                                                      : ~dev_byte(bsel[0], rd_val[breg[0]]);
  assign bdi[1] = (!cs_n[1] && low_cnt[1] == T1 - 1) ? dev_byte(bsel[1], rd_val[breg[1]])
                                                      : ~dev_byte(bsel[1], rd_val[breg[1]]);

  // Monitor: one record per strobe (fields captured on its first cycle),
  // one record per accepted response.
  byte_t cur_b [2];
  bit    in_low [2];
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        in_low[i] = 1'b0;
      end else if (!cs_n[i]) begin
        if (!in_low[i]) begin
          cur_b[i].rd    = bus_rd[i];
          cur_b[i].bsel  = bsel[i];
          cur_b[i].rnum  = breg[i];
          cur_b[i].data  = bdo[i];
          cur_b[i].len   = 0;
          cur_b[i].start = cyc;
          in_low[i]      = 1'b1;
        end
        cur_b[i].len = cur_b[i].len + 1;
      end else if (in_low[i]) begin
        in_low[i] = 1'b0;
        if (i == 0) mon_q0.push_back(cur_b[i]);
        else        mon_q1.push_back(cur_b[i]);
      end
      if (!rst && rsp_valid[i] && rsp_ready[i]) begin
        rsp_t r;
        r.data = rsp_data[i];
        r.rnum = rsp_reg[i];
        if (i == 0) got_r0.push_back(r);
        else        got_r1.push_back(r);
      end
    end
  end

  // Reference model: what the bus and response port must show for one command.
  task automatic model_cmd(input int i, input bit rd, input logic [3:0] r,
                           input logic [1:0] m, input logic [15:0] d);
    bit    word;
    byte_t b;
    rsp_t  rs;
    word   = (m == 2'b00) || (m == 2'b11);
    b.rd   = rd;
    b.rnum = r;
    b.len  = 0;
    b.start = 0;
    if (word || m == 2'b01) begin
      b.bsel = 1'b0;
      b.data = rd ? 8'h00 : d[15:8];
      if (i == 0) exp_q0.push_back(b); else exp_q1.push_back(b);
    end
    if (word || m == 2'b10) begin
      b.bsel = 1'b1;
      b.data = rd ? 8'h00 : d[7:0];
      if (i == 0) exp_q0.push_back(b); else exp_q1.push_back(b);
    end
    if (rd) begin
      rs.rnum = r;
      rs.data = {(word || m == 2'b01) ? rd_val[r][15:8] : 8'h00,
                 (word || m == 2'b10) ? rd_val[r][7:0]  : 8'h00};
      if (i == 0) exp_r0.push_back(rs); else exp_r1.push_back(rs);
    end
  endtask

  // Present a command until accepted; returns stall cycles and the cycle
  // number of the accepting edge. Leaves time at posedge+1.
  task automatic send(input int i, input bit rd, input logic [3:0] r, input logic [1:0] m,
                      input logic [15:0] d, output int stalls, output int acc);
    bit ok;
    cmd_valid[i] = 1'b1;
    cmd_rd[i]    = rd;
    cmd_reg[i]   = r;
    cmd_mode[i]  = m;
    cmd_data[i]  = d;
    stalls = 0;
    acc    = -1;
    ok     = 1'b0;
    while (!ok && stalls < 300) begin
      @(negedge clk);
      if (cmd_ready[i]) begin
        ok = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
      end else begin
        stalls++;
      end
    end
    cmd_valid[i] = 1'b0;
    if (ok) begin
      model_cmd(i, rd, r, m, d);
    end else begin
      total++;
      bad++;
      $display("FAIL send_timeout dut%0d got=ready_low expected=accept", i);
    end
  endtask

  task automatic wait_idle(input int i, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy[i] || rsp_valid[i]) && n < budget);
    if (busy[i] || rsp_valid[i]) begin
      total++;
      bad++;
      $display("FAIL idle_timeout dut%0d got=busy expected=idle within %0d", i, budget);
    end
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_queues();
    mon_q0.delete(); exp_q0.delete(); got_r0.delete(); exp_r0.delete();
    mon_q1.delete(); exp_q1.delete(); got_r1.delete(); exp_r1.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cmd_valid[i] = 1'b0; cmd_rd[i] = 1'b0; cmd_reg[i] = '0;
      cmd_mode[i] = '0; cmd_data[i] = '0; rsp_ready[i] = 1'b1;
    end
    repeat (3) @(negedge clk);
    total += 6;
    if (cs_n[0] !== 1'b1)   begin bad++; $display("FAIL reset_cs_n got=%b expected=1", cs_n[0]); end
    if (bus_rd[0] !== 1'b1) begin bad++; $display("FAIL reset_rd_nwr got=%b expected=1", bus_rd[0]); end
    if ({bsel[0], breg[0], bdo[0]} !== 13'h0)
      begin bad++; $display("FAIL reset_bus got=sel%b reg%h d%h expected=0", bsel[0], breg[0], bdo[0]); end
    if (rsp_valid[0] !== 1'b0 || rsp_data[0] !== 16'h0)
      begin bad++; $display("FAIL reset_rsp got=v%b d%h expected=v0 d0000", rsp_valid[0], rsp_data[0]); end
    if (busy[0] !== 1'b0)   begin bad++; $display("FAIL reset_busy got=%b expected=0", busy[0]); end
    if (cs_n[1] !== 1'b1)   begin bad++; $display("FAIL reset_cs_n_fast got=%b expected=1", cs_n[1]); end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (cmd_ready[0] !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b expected=1", cmd_ready[0]); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_word();
    int st, acc, nbusy;
    clear_queues();
    send(0, 1'b0, 4'h5, 2'b00, 16'h1234, st, acc);
    nbusy = 0;
    do begin
      @(negedge clk);
      if (busy[0]) nbusy++;
    end while (busy[0] && nbusy < 100);
    // one IDLE cycle with a queued entry, then 1 + 2*(1+4+4) from LOAD
    total++;
    if (nbusy != 20) begin bad++; $display("FAIL ww_busy_cycles got=%0d expected=20", nbusy); end
    repeat (2) @(negedge clk);
    total++;
    if (mon_q0.size() != 2) begin
      bad++; $display("FAIL ww_strobes got=%0d expected=2", mon_q0.size());
    end else begin
      total += 4;
      if (mon_q0[0].bsel !== 1'b0 || mon_q0[0].data !== 8'h12 || mon_q0[0].rnum !== 4'h5 || mon_q0[0].rd !== 1'b0)
        begin bad++; $display("FAIL ww_byte0 got=sel%b d%h reg%h rd%b expected=sel0 d12 reg5 rd0",
                              mon_q0[0].bsel, mon_q0[0].data, mon_q0[0].rnum, mon_q0[0].rd); end
      if (mon_q0[1].bsel !== 1'b1 || mon_q0[1].data !== 8'h34 || mon_q0[1].rnum !== 4'h5)
        begin bad++; $display("FAIL ww_byte1 got=sel%b d%h reg%h expected=sel1 d34 reg5",
                              mon_q0[1].bsel, mon_q0[1].data, mon_q0[1].rnum); end
      if (mon_q0[0].len != 4 || mon_q0[1].len != 4)
        begin bad++; $display("FAIL ww_strobe_len got=%0d,%0d expected=4,4", mon_q0[0].len, mon_q0[1].len); end
      // push edge -> LOAD -> 1 SETUP -> strobe, then 9 cycles per byte
      if (mon_q0[0].start != acc + 3 || mon_q0[1].start != mon_q0[0].start + 9)
        begin bad++; $display("FAIL ww_timing got=%0d,%0d expected=%0d,%0d",
                              mon_q0[0].start - acc, mon_q0[1].start - acc, 3, 12); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_read_hold();
    int st, acc, n;
    clear_queues();
    rd_val[10] = 16'hBEEF;
    rsp_ready[0] = 1'b0;
    send(0, 1'b1, 4'hA, 2'b00, 16'h0000, st, acc);
    send(0, 1'b0, 4'h3, 2'b00, 16'($urandom), st, acc);
    send(0, 1'b0, 4'h4, 2'b00, 16'($urandom), st, acc);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid[0] && n < 200);
    total += 2;
    if (rsp_data[0] !== 16'hBEEF) begin bad++; $display("FAIL rd_data got=%h expected=beef", rsp_data[0]); end
    if (rsp_reg[0] !== 4'hA)      begin bad++; $display("FAIL rd_reg got=%h expected=a", rsp_reg[0]); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      total++;
      if (rsp_valid[0] !== 1'b1 || cs_n[0] !== 1'b1 || busy[0] !== 1'b1)
        begin bad++; $display("FAIL rd_hold%0d got=v%b cs%b busy%b expected=v1 cs1 busy1",
                              k, rsp_valid[0], cs_n[0], busy[0]); end
    end
    total++;
    if (mon_q0.size() != 2) begin bad++; $display("FAIL rd_hold_strobes got=%0d expected=2", mon_q0.size()); end
    @(posedge clk);
    #1;
    rsp_ready[0] = 1'b1;
    wait_idle(0, 300);
    total++;
    if (got_r0.size() != 1 || exp_r0.size() != 1) begin
      bad++; $display("FAIL rd_rsp_count got=%0d expected=1", got_r0.size());
    end
    total++;
    if (mon_q0.size() != exp_q0.size()) begin
      bad++; $display("FAIL rd_stream_len got=%0d expected=%0d", mon_q0.size(), exp_q0.size());
    end
    for (int k = 0; k < mon_q0.size() && k < exp_q0.size(); k++) begin
      total++;
      if (mon_q0[k].rd !== exp_q0[k].rd || mon_q0[k].bsel !== exp_q0[k].bsel ||
          mon_q0[k].rnum !== exp_q0[k].rnum || mon_q0[k].data !== exp_q0[k].data || mon_q0[k].len != T0)
        begin bad++; $display("FAIL rd_stream%0d got=rd%b sel%b reg%h d%h len%0d expected=rd%b sel%b reg%h d%h len%0d",
                              k, mon_q0[k].rd, mon_q0[k].bsel, mon_q0[k].rnum, mon_q0[k].data, mon_q0[k].len,
                              exp_q0[k].rd, exp_q0[k].bsel, exp_q0[k].rnum, exp_q0[k].data, T0); end
    end
  endtask

  task automatic test_modes();
    int st, acc;
    clear_queues();
    send(0, 1'b0, 4'h3, 2'b10, 16'h00AB, st, acc);          // LO write
    send(0, 1'b1, 4'h7, 2'b01, 16'h0000, st, acc);          // HI read
    send(0, 1'b0, 4'h9, 2'b11, 16'($urandom), st, acc);     // mode 11 write
    send(0, 1'b1, 4'hC, 2'b10, 16'h0000, st, acc);          // LO read
    send(0, 1'b1, 4'h2, 2'b11, 16'h0000, st, acc);          // mode 11 read
    wait_idle(0, 500);
    total++;
    if (mon_q0.size() == 0 || mon_q0[0].bsel !== 1'b1 || mon_q0[0].data !== 8'hAB)
      begin bad++; $display("FAIL mode_lo_first got=n%0d expected=sel1 dab", mon_q0.size()); end
    total++;
    if (mon_q0.size() != exp_q0.size()) begin
      bad++; $display("FAIL mode_stream_len got=%0d expected=%0d", mon_q0.size(), exp_q0.size());
    end
    for (int k = 0; k < mon_q0.size() && k < exp_q0.size(); k++) begin
      total++;
      if (mon_q0[k].rd !== exp_q0[k].rd || mon_q0[k].bsel !== exp_q0[k].bsel ||
          mon_q0[k].rnum !== exp_q0[k].rnum || mon_q0[k].data !== exp_q0[k].data || mon_q0[k].len != T0)
        begin bad++; $display("FAIL mode_stream%0d got=rd%b sel%b reg%h d%h len%0d expected=rd%b sel%b reg%h d%h",
                              k, mon_q0[k].rd, mon_q0[k].bsel, mon_q0[k].rnum, mon_q0[k].data, mon_q0[k].len,
                              exp_q0[k].rd, exp_q0[k].bsel, exp_q0[k].rnum, exp_q0[k].data); end
    end
    total++;
    if (got_r0.size() != exp_r0.size()) begin
      bad++; $display("FAIL mode_rsp_count got=%0d expected=%0d", got_r0.size(), exp_r0.size());
    end
    for (int k = 0; k < got_r0.size() && k < exp_r0.size(); k++) begin
      total++;
      if (got_r0[k].data !== exp_r0[k].data || got_r0[k].rnum !== exp_r0[k].rnum)
        begin bad++; $display("FAIL mode_rsp%0d got=%h/%h expected=%h/%h", k,
                              got_r0[k].data, got_r0[k].rnum, exp_r0[k].data, exp_r0[k].rnum); end
    end
  endtask

  task automatic test_back_to_back();
    int st [6];
    int acc;
    int early;
    clear_queues();
    for (int k = 0; k < 6; k++) begin
      send(0, 1'($urandom_range(0, 1)), 4'($urandom), 2'($urandom), 16'($urandom), st[k], acc);
    end
    // one entry is popped while the FIFO fills, so five go in unstalled
    early = st[0] + st[1] + st[2] + st[3] + st[4];
    total += 2;
    if (early != 0) begin bad++; $display("FAIL b2b_early_stalls got=%0d expected=0", early); end
    if (st[5] == 0) begin bad++; $display("FAIL b2b_full_stall got=%0d expected=>0", st[5]); end
    wait_idle(0, 1000);
    total++;
    if (mon_q0.size() != exp_q0.size()) begin
      bad++; $display("FAIL b2b_stream_len got=%0d expected=%0d", mon_q0.size(), exp_q0.size());
    end
    for (int k = 0; k < mon_q0.size() && k < exp_q0.size(); k++) begin
      total++;
      if (mon_q0[k].rd !== exp_q0[k].rd || mon_q0[k].bsel !== exp_q0[k].bsel ||
          mon_q0[k].rnum !== exp_q0[k].rnum || mon_q0[k].data !== exp_q0[k].data || mon_q0[k].len != T0)
        begin bad++; $display("FAIL b2b_stream%0d got=rd%b sel%b reg%h d%h len%0d expected=rd%b sel%b reg%h d%h",
                              k, mon_q0[k].rd, mon_q0[k].bsel, mon_q0[k].rnum, mon_q0[k].data, mon_q0[k].len,
                              exp_q0[k].rd, exp_q0[k].bsel, exp_q0[k].rnum, exp_q0[k].data); end
    end
    total++;
    if (got_r0.size() != exp_r0.size()) begin
      bad++; $display("FAIL b2b_rsp_count got=%0d expected=%0d", got_r0.size(), exp_r0.size());
    end
    for (int k = 0; k < got_r0.size() && k < exp_r0.size(); k++) begin
      total++;
      if (got_r0[k].data !== exp_r0[k].data || got_r0[k].rnum !== exp_r0[k].rnum)
        begin bad++; $display("FAIL b2b_rsp%0d got=%h/%h expected=%h/%h", k,
                              got_r0[k].data, got_r0[k].rnum, exp_r0[k].data, exp_r0[k].rnum); end
    end
  endtask

  task automatic test_reset_mid();
    int st, acc, n;
    clear_queues();
    send(0, 1'b0, 4'h6, 2'b00, 16'hCAFE, st, acc);
    send(0, 1'b0, 4'h8, 2'b00, 16'h5A5A, st, acc);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(!cs_n[0] && low_cnt[0] == 1) && n < 100);
    total++;
    if (n >= 100) begin bad++; $display("FAIL rm_no_strobe got=timeout expected=strobe"); end
    rst = 1'b1;
    #1;
    total += 3;
    if (cs_n[0] !== 1'b1)      begin bad++; $display("FAIL rm_cs_async got=%b expected=1", cs_n[0]); end
    if (busy[0] !== 1'b0)      begin bad++; $display("FAIL rm_busy got=%b expected=0", busy[0]); end
    if (cmd_ready[0] !== 1'b1) begin bad++; $display("FAIL rm_ready got=%b expected=1", cmd_ready[0]); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mon_q0.delete();
    repeat (60) @(negedge clk);
    total += 2;
    if (mon_q0.size() != 0) begin bad++; $display("FAIL rm_extra_strobes got=%0d expected=0", mon_q0.size()); end
    if (busy[0] !== 1'b0 || cs_n[0] !== 1'b1)
      begin bad++; $display("FAIL rm_after got=busy%b cs%b expected=busy0 cs1", busy[0], cs_n[0]); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_fast();
    int st, acc;
    clear_queues();
    send(1, 1'b1, 4'h2, 2'b00, 16'h0000, st, acc);
    send(1, 1'b0, 4'hE, 2'b00, 16'($urandom), st, acc);
    wait_idle(1, 300);
    total++;
    if (mon_q1.size() != 4) begin
      bad++; $display("FAIL fast_strobes got=%0d expected=4", mon_q1.size());
    end else begin
      total += 2;
      if (mon_q1[1].start - mon_q1[0].start != 4 || mon_q1[3].start - mon_q1[2].start != 4)
        begin bad++; $display("FAIL fast_period got=%0d,%0d expected=4,4",
                              mon_q1[1].start - mon_q1[0].start, mon_q1[3].start - mon_q1[2].start); end
      if (mon_q1[0].len != T1 || mon_q1[3].len != T1 || mon_q1[3].data !== exp_q1[3].data)
        begin bad++; $display("FAIL fast_bytes got=len%0d d%h expected=len%0d d%h",
                              mon_q1[3].len, mon_q1[3].data, T1, exp_q1[3].data); end
    end
    total++;
    if (got_r1.size() != 1 || got_r1[0].data !== exp_r1[0].data || got_r1[0].rnum !== 4'h2)
      begin bad++; $display("FAIL fast_read got=n%0d expected=%h", got_r1.size(), exp_r1[0].data); end
  endtask

  initial begin
    for (int k = 0; k < 16; k++) rd_val[k] = 16'($urandom);
    test_reset();
    test_write_word();
    test_read_hold();
    test_modes();
    test_back_to_back();
    test_reset_mid();
    test_fast();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
